// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/handshake/PC-control bundle between the decoder and the PC sequencer
//
// Purpose : groups the decode requests, the external input handshake and
//           the PC control/debug outputs of pc_sequencer.
// Ports   : master - decoder/environment side (drives requests, in_valid)
//           slave  - pc_sequencer side (drives PCincr/PCrel/PCoff, in_ack,
//                    busy, halted, retired)
interface pc_sequencer_if #(
    parameter int Psize = 6,
    parameter int Csize = 16
);
    logic             start;
    logic             halt_req;
    logic             wait_req;
    logic             br_req;
    logic             br_cond;
    logic [Psize-1:0] br_off;
    logic             in_valid;
    logic             PCincr;
    logic             PCrel;
    logic [Psize-1:0] PCoff;
    logic             in_ack;
    logic             busy;
    logic             halted;
    logic [Csize-1:0] retired;

    modport master (
        output start, halt_req, wait_req, br_req, br_cond, br_off, in_valid,
        input  PCincr, PCrel, PCoff, in_ack, busy, halted, retired
    );

    modport slave (
        input  start, halt_req, wait_req, br_req, br_cond, br_off, in_valid,
        output PCincr, PCrel, PCoff, in_ack, busy, halted, retired
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - picoMIPS program-counter sequencing FSM with input handshake and retire counter
//
// Purpose : decides each cycle whether the external PC holds, increments or
//           takes a relative branch; handles wait-for-input with press and
//           release; stops on HALT; counts retired instructions (saturating).
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset (to IDLE, retired=0)
//           bus  - pc_sequencer_if.slave (decode inputs, in_valid, PC
//                  control outputs, in_ack, busy, halted, retired)
module pc_sequencer #(
    parameter int Psize = 6,
    parameter int Csize = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_REL,
        S_HALT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [Csize-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mealy outputs: everything is combinational from state and decode inputs,
    // so the external PC register sees the update at the very next edge.
    always_comb begin
        state_nxt  = state;
        bus.PCincr = 1'b0;
        bus.PCrel  = 1'b0;
        bus.PCoff  = {Psize{1'b0}};
        bus.in_ack = 1'b0;
        bus.busy   = 1'b0;
        bus.halted = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                // HALT beats everything and suppresses the PC update.
                if (bus.halt_req) begin
                    state_nxt = S_HALT;
                end else if (bus.wait_req) begin
                    state_nxt = S_WAIT;
                end else if (bus.br_req && bus.br_cond) begin
                    bus.PCrel = 1'b1;
                    bus.PCoff = bus.br_off;
                end else begin
                    bus.PCincr = 1'b1;
                end
            end
            S_WAIT: begin
                bus.busy = 1'b1;
                if (bus.in_valid) begin
                    bus.in_ack = 1'b1;
                    bus.PCincr = 1'b1;
                    state_nxt  = S_REL;
                end
            end
            S_REL: begin
                // Hold until the input is released so one press cannot
                // satisfy two back-to-back waits.
                bus.busy = 1'b1;
                if (!bus.in_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= {Csize{1'b0}};
        end else if ((bus.PCincr || bus.PCrel) && (cnt != {Csize{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.retired = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pc_sequencer_if #(.Psize(6), .Csize(16)) m_if ();
    pc_sequencer_if #(.Psize(6), .Csize(4))  s_if ();

    pc_sequencer #(.Psize(6), .Csize(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    pc_sequencer #(.Psize(6), .Csize(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    // {PCincr, PCrel, in_ack, busy, halted}
    wire [4:0] mf = {m_if.PCincr, m_if.PCrel, m_if.in_ack, m_if.busy, m_if.halted};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_if.start = 0; m_if.halt_req = 0; m_if.wait_req = 0; m_if.br_req = 0;
        m_if.br_cond = 0; m_if.br_off = '0; m_if.in_valid = 0;
        s_if.start = 0; s_if.halt_req = 0; s_if.wait_req = 0; s_if.br_req = 0;
        s_if.br_cond = 0; s_if.br_off = '0; s_if.in_valid = 0;

        // reset held two cycles, start asserted to show rst wins
        m_if.start = 1;
        #3;
        check("rst_flags", 32'(mf), 0);
        check("rst_ret", 32'(m_if.retired), 0);
        tick();
        tick();
        m_if.start = 0;
        rst = 0;

        for (int i = 0; i < 3; i++) begin
            #3;
            check("idle_flags", 32'(mf), 0);
            check("idle_ret", 32'(m_if.retired), 0);
            check("idle_off", 32'(m_if.PCoff), 0);
            tick();
        end

        // start: transition cycle does not advance the PC
        m_if.start = 1;
        #3;
        check("start_cyc", 32'(mf), 0);
        tick();
        m_if.start = 0;

        for (int i = 0; i < 4; i++) begin
            #3;
            check("run_flags", 32'(mf), 5'b10010);
            tick();
        end
        #3;
        check("ret_after_run", 32'(m_if.retired), 4);

        // taken branch, backwards offset -3
        m_if.br_req = 1; m_if.br_cond = 1; m_if.br_off = 6'b111101;
        #3;
        check("br_taken_flags", 32'(mf), 5'b01010);
        check("br_taken_off", 32'(m_if.PCoff), 6'h3d);
        tick();

        m_if.br_cond = 0;
        #3;
        check("br_nt_flags", 32'(mf), 5'b10010);
        check("br_nt_off", 32'(m_if.PCoff), 0);
        check("ret_br_taken", 32'(m_if.retired), 5);
        tick();

        // wait handshake
        m_if.br_req = 0; m_if.wait_req = 1;
        #3;
        check("ret_br_nt", 32'(m_if.retired), 6);
        check("wait_req_flags", 32'(mf), 5'b00010);
        tick();
        m_if.wait_req = 0;

        for (int i = 0; i < 5; i++) begin
            #3;
            check("wait_idle_flags", 32'(mf), 5'b00010);
            check("wait_idle_ret", 32'(m_if.retired), 6);
            tick();
        end

        m_if.in_valid = 1;
        #3;
        check("wait_ack_flags", 32'(mf), 5'b10110);
        tick();
        for (int i = 0; i < 2; i++) begin
            #3;
            check("rel_held_flags", 32'(mf), 5'b00010);
            tick();
        end
        m_if.in_valid = 0;
        #3;
        check("rel_release_flags", 32'(mf), 5'b00010);
        tick();
        #3;
        check("run_resume_flags", 32'(mf), 5'b10010);
        check("ret_after_wait", 32'(m_if.retired), 7);
        tick();

        // halt together with a taken branch: no PC update
        m_if.halt_req = 1; m_if.br_req = 1; m_if.br_cond = 1; m_if.br_off = 6'h3d;
        #3;
        check("halt_cyc_flags", 32'(mf), 5'b00010);
        check("halt_cyc_off", 32'(m_if.PCoff), 0);
        check("halt_cyc_ret", 32'(m_if.retired), 8);
        tick();
        m_if.halt_req = 0; m_if.br_req = 0; m_if.br_cond = 0;
        #3;
        check("halted_flags", 32'(mf), 5'b00001);
        tick();
        m_if.start = 1;
        tick();
        m_if.start = 0;
        m_if.wait_req = 1;
        tick();
        m_if.wait_req = 0;
        #3;
        check("halt_sticky_flags", 32'(mf), 5'b00001);
        check("halt_sticky_ret", 32'(m_if.retired), 8);

        // async reset out of HALT
        #1 rst = 1;
        #1;
        check("rst_halt_flags", 32'(mf), 0);
        check("rst_halt_ret", 32'(m_if.retired), 0);
        tick();
        rst = 0;

        // reset in the middle of a WAIT completion
        m_if.start = 1;
        tick();
        m_if.start = 0;
        #3;
        check("run2_flags", 32'(mf), 5'b10010);
        tick();
        m_if.wait_req = 1;
        #3;
        check("run2_ret", 32'(m_if.retired), 1);
        tick();
        m_if.wait_req = 0;
        m_if.in_valid = 1;
        #3;
        check("wait2_ack_flags", 32'(mf), 5'b10110);
        #1 rst = 1;
        #1;
        check("rst_wait_flags", 32'(mf), 0);
        check("rst_wait_ack", 32'(m_if.in_ack), 0);
        check("rst_wait_ret", 32'(m_if.retired), 0);
        tick();
        rst = 0;
        m_if.in_valid = 0;
        #3;
        check("post_rst_idle", 32'(mf), 0);

        // saturation on the 4-bit counter instance
        s_if.start = 1;
        tick();
        s_if.start = 0;
        for (int i = 0; i < 20; i++) begin
            #3;
            check("sat_incr", 32'(s_if.PCincr), 1);
            check("sat_ret", 32'(s_if.retired), (i > 15) ? 15 : i);
            tick();
        end
        #3;
        check("sat_final", 32'(s_if.retired), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
